// File: rtl/serial2tcp_fifo_loopback.sv
// Buffered serial2tcp loopback: sink words are transformed, queued in a DEPTH-entry
// FIFO and replayed on the source stream, with traffic counters and a fill level.
module serial2tcp_fifo_loopback #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [1:0]                 mode,
  input  logic                       flush,
  input  logic                       serial2tcp_sink_valid,
  output logic                       serial2tcp_sink_ready,
  input  logic [DATA_W-1:0]          serial2tcp_sink_data,
  output logic                       serial2tcp_source_valid,
  input  logic                       serial2tcp_source_ready,
  output logic [DATA_W-1:0]          serial2tcp_source_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           rx_count,
  output logic [CNT_W-1:0]           tx_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    MODE_ECHO = 2'd0,
    MODE_INV  = 2'd1,
    MODE_INC  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] xf_data;
  logic              push;
  logic              pop;

  assign serial2tcp_sink_ready   = (level != LW'(DEPTH)) & sys_rst_n & ~flush;
  assign serial2tcp_source_valid = (level != '0);
  assign serial2tcp_source_data  = mem[rd_ptr];

  assign push = serial2tcp_sink_valid & serial2tcp_sink_ready;
  assign pop  = serial2tcp_source_valid & serial2tcp_source_ready;

  always_comb begin
    xf_data = serial2tcp_sink_data;
    case (mode_t'(mode))
      MODE_INV: xf_data = ~serial2tcp_sink_data;
      MODE_INC: xf_data = serial2tcp_sink_data + DATA_W'(1);
      default:  xf_data = serial2tcp_sink_data;
    endcase
  end

  // push already excludes reset and flush, so storage needs no reset term
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= xf_data;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rx_count <= '0;
      tx_count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        rx_count <= rx_count + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        tx_count <= tx_count + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_serial2tcp_fifo_loopback.sv
// Directed bench for serial2tcp_fifo_loopback with a queue scoreboard of expected output words.
module tb_serial2tcp_fifo_loopback;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [1:0]  mode;
  logic        flush;
  logic        sink_valid;
  logic        sink_ready;
  logic [7:0]  sink_data;
  logic        source_valid;
  logic        source_ready;
  logic [7:0]  source_data;
  logic [4:0]  level;
  logic [31:0] rx_count;
  logic [31:0] tx_count;

  int tests = 0;
  int fails = 0;
  logic [7:0] q[$];
  int unsigned rx_m = 0;
  int unsigned tx_m = 0;

  always #5 sys_clk = ~sys_clk;

  serial2tcp_fifo_loopback #(.DATA_W(8), .DEPTH(16), .CNT_W(32)) dut (
    .sys_clk                 (sys_clk),
    .sys_rst_n               (sys_rst_n),
    .mode                    (mode),
    .flush                   (flush),
    .serial2tcp_sink_valid   (sink_valid),
    .serial2tcp_sink_ready   (sink_ready),
    .serial2tcp_sink_data    (sink_data),
    .serial2tcp_source_valid (source_valid),
    .serial2tcp_source_ready (source_ready),
    .serial2tcp_source_data  (source_data),
    .level                   (level),
    .rx_count                (rx_count),
    .tx_count                (tx_count)
  );

  function automatic logic [7:0] xf(input logic [7:0] d, input logic [1:0] m);
    case (m)
      2'd1:    return ~d;
      2'd2:    return d + 8'd1;
      default: return d;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check outputs at the negedge, predict the coming edge, then advance past it.
  task automatic step();
    logic exp_ready, exp_valid, do_push, do_pop;
    @(negedge sys_clk);
    exp_ready = (q.size() != 16) && sys_rst_n && !flush;
    exp_valid = (q.size() != 0);
    check("sink_ready", 64'(sink_ready), 64'(exp_ready));
    check("source_valid", 64'(source_valid), 64'(exp_valid));
    check("level", 64'(level), 64'(q.size()));
    check("rx_count", 64'(rx_count), 64'(rx_m));
    check("tx_count", 64'(tx_count), 64'(tx_m));
    do_push = sink_valid && exp_ready;
    do_pop  = exp_valid && source_ready && sys_rst_n && !flush;
    if (do_pop) begin
      check("source_data", 64'(source_data), 64'(q[0]));
      void'(q.pop_front());
      tx_m++;
    end
    if (!sys_rst_n) begin
      q.delete();
      rx_m = 0;
      tx_m = 0;
    end else if (flush) begin
      q.delete();
    end else if (do_push) begin
      q.push_back(xf(sink_data, mode));
      rx_m++;
    end
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int unsigned rx_before;
    sys_rst_n = 1'b0; mode = 2'd0; flush = 1'b0;
    sink_valid = 1'b1; sink_data = 8'h77; source_ready = 1'b0;
    @(posedge sys_clk); #1;

    // Reset held with sink_valid asserted
    repeat (3) step();
    check("reset_rx", 64'(rx_count), 64'd0);
    sys_rst_n = 1'b1; sink_valid = 1'b0;
    step();
    check("post_reset_level", 64'(level), 64'd0);

    // Echo stream 0x00..0xFF
    source_ready = 1'b1; sink_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      sink_data = 8'(i);
      step();
    end
    sink_valid = 1'b0;
    repeat (2) step();
    check("echo_rx", 64'(rx_count), 64'd256);
    check("echo_tx", 64'(tx_count), 64'd256);

    // Fill with backpressure: 20 offered, 16 accepted
    source_ready = 1'b0; sink_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sink_data = 8'(8'h30 + i);
      step();
    end
    check("full_level", 64'(level), 64'd16);
    check("full_ready", 64'(sink_ready), 64'd0);
    check("full_rx", 64'(rx_count), 64'd272);

    // Push and pop offered at full: pop only, then push+pop holds level
    source_ready = 1'b1; sink_data = 8'hC3;
    step();
    check("full_pop_level", 64'(level), 64'd15);
    sink_data = 8'hC4;
    step();
    check("hold_level", 64'(level), 64'd15);
    sink_valid = 1'b0;
    repeat (17) step();
    check("drained", 64'(level), 64'd0);

    // Transform sampled at push time
    source_ready = 1'b0; sink_valid = 1'b1;
    mode = 2'd1; sink_data = 8'h5A; step();
    mode = 2'd2; sink_data = 8'hFF; step();
    mode = 2'd3; sink_data = 8'h10; step();
    sink_valid = 1'b0; mode = 2'd0;
    check("mode_q0", 64'(q[0]), 64'hA5);
    check("mode_q1", 64'(q[1]), 64'h00);
    check("mode_q2", 64'(q[2]), 64'h10);
    source_ready = 1'b1;
    repeat (4) step();

    // Flush with a push and pop offered
    rx_before = rx_m;
    source_ready = 1'b0; sink_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sink_data = 8'(8'h90 + i);
      step();
    end
    check("pre_flush_level", 64'(level), 64'd5);
    flush = 1'b1; source_ready = 1'b1; sink_data = 8'hEE;
    step();
    flush = 1'b0; sink_valid = 1'b0;
    step();
    check("flush_level", 64'(level), 64'd0);
    check("flush_valid", 64'(source_valid), 64'd0);
    check("flush_rx", 64'(rx_count), 64'(rx_before + 5));
    sink_valid = 1'b1; sink_data = 8'h42;
    step();
    sink_valid = 1'b0;
    repeat (2) step();

    // Mid-stream reset discards contents and clears counters
    source_ready = 1'b0; sink_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sink_data = 8'(8'h20 + i);
      step();
    end
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1; sink_valid = 1'b0;
    step();
    check("midreset_rx", 64'(rx_count), 64'd0);
    check("midreset_level", 64'(level), 64'd0);
    source_ready = 1'b1; sink_valid = 1'b1; sink_data = 8'h11;
    step();
    sink_valid = 1'b0;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial2tcp_fifo_loopback.md
# serial2tcp_fifo_loopback

Buffered, parametrised loopback for the serial2tcp streaming bridge: bytes (or DATA_W-bit words) accepted on the sink stream are optionally transformed, stored in a DEPTH-entry FIFO, and replayed on the source stream. The FIFO decouples sink and source backpressure. Traffic counters and a fill level support host-side throughput tests. The block sits between the serial2tcp PHY streams and replaces the combinational wire-through loopback in test builds.

## Interface

Parameters:
- DATA_W, 8: stream data width in bits (≥1).
- DEPTH, 16: FIFO entries; power of two, ≥2.
- CNT_W, 32: width of the rx/tx word counters.

Ports:
- sys_clk  in  1  single clock for everything.
- sys_rst_n  in  1  reset; synchronous, active-low.
- mode  in  2  transform applied at write time: 0 echo, 1 bitwise invert, 2 increment (data+1 mod 2^DATA_W), 3 reserved (treated as echo).
- flush  in  1  synchronous FIFO clear, active-high.
- serial2tcp_sink_valid  in  1  input word valid.
- serial2tcp_sink_ready  out  1  block can accept the input word.
- serial2tcp_sink_data  in  DATA_W  input word.
- serial2tcp_source_valid  out  1  output word valid.
- serial2tcp_source_ready  in  1  downstream accepts the output word.
- serial2tcp_source_data  out  DATA_W  output word.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- rx_count  out  CNT_W  words accepted on sink since reset.
- tx_count  out  CNT_W  words delivered on source since reset.

## Operation

- Push: sink_valid & sink_ready at a rising edge. The transformed word is written at wr_ptr, wr_ptr increments, and rx_count increments.
- Pop: source_valid & source_ready at a rising edge. rd_ptr increments and tx_count increments.
- sink_ready = (level != DEPTH) & sys_rst_n & ~flush. It is a function of registered state plus those inputs only, never of sink_valid.
- source_valid = (level != 0). source_data = mem[rd_ptr] and must be stable while valid & ~ready.
- Transform is sampled with the word at push time. A mode change never alters words already stored.
- Pointers are $clog2(DEPTH) bits and wrap naturally DEPTH-1 → 0.
- level is a registered counter:
  - +1 on push only.
  - −1 on pop only.
  - unchanged on simultaneous push and pop, including at level==DEPTH-1 and level==1.
- Full (level==DEPTH): sink_ready=0. A pop in that cycle frees a slot, and ready rises on the next cycle. There is no same-cycle full bypass.
- Empty (level==0): source_valid=0. A push becomes visible on the next cycle. There is no combinational sink→source path.
- Counters wrap modulo 2^CNT_W silently.
- flush=1 (sampled at the edge):
  - level, wr_ptr and rd_ptr are set to 0. Stored words are discarded.
  - No push occurs (sink_ready=0). A pop presented in that cycle is not counted.
  - Counters are NOT cleared.
- Memory contents need no reset.

## Timing

- Reset, sys_rst_n=0 at an edge: level=0, pointers=0, rx_count=0, tx_count=0.
- Outputs follow from that state: source_valid=0, source_data undefined/don't-care, sink_ready=0 while sys_rst_n=0.
- A reset mid-stream discards FIFO contents exactly like flush and also clears the counters.
- First-word latency: a word pushed at edge N has source_valid=1 after edge N (usable at edge N+1).
- Throughput: one word per cycle sustained when both sides are always ready. The FIFO stays at constant level.
- All outputs are registered state or simple decodes of it, except the sys_rst_n/flush terms in sink_ready.

## Test plan

- Reset/idle: hold sys_rst_n=0 for 3 cycles with sink_valid=1 → sink_ready=0, source_valid=0, counters 0, and no push recorded after release.
- Echo stream, DATA_W=8, DEPTH=16: push 0x00..0xFF back-to-back with source_ready=1 → identical sequence out, one per cycle after 1-cycle latency, level ≤1, rx_count=tx_count=256.
- Fill/backpressure: source_ready=0, push 20 words → exactly 16 accepted, level=16, sink_ready=0. Release source_ready → 16 words in order, then ready returns one cycle after the first pop.
- Simultaneous at full: level=16, push and pop offered the same cycle → pop only, level=15, next cycle push+pop holds level=15.
- Modes: push 0x5A with mode=1, then 0xFF with mode=2, then 0x10 with mode=3, and switch mode to 0 before any pop → output 0xA5, 0x00, 0x10.
- Flush: level=5, rx_count=5, assert flush one cycle while offering a push → level=0, source_valid=0, rx_count stays 5, and the next push/pop pair works normally.
